// File: rtl/axi_pkg.sv
// Shared AXI encodings for the read-side blocks: burst types, response codes
// and the read-slave FSM state type.
package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } burst_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_state_e;

  // Only FIXED and INCR are backed by memory; WRAP and the reserved code error out.
  function automatic logic burst_supported(input logic [1:0] burst);
    logic ok;
    case (burst)
      FIXED, INCR: ok = 1'b1;
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry in-order output buffer for the R channel. The head entry drives the
// outputs directly from a register, so the payload holds while out_valid & !pop_ready.
module rd_skid_buf
  import axi_pkg::*;
#(
  parameter int W = 39
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] ent0_r, ent0_s;
  logic [W-1:0] ent1_r, ent1_s;
  logic [1:0]   cnt_r, cnt_s;
  logic         vld_r;
  logic         pop_s;

  assign pop_s     = vld_r & pop_ready;
  assign out_valid = vld_r;
  assign out_data  = ent0_r;
  assign count     = cnt_r;

  // Next-state of the two entries; ent0 is always the oldest beat.
  always_comb begin
    ent0_s = ent0_r;
    ent1_s = ent1_r;
    cnt_s  = cnt_r;
    case ({push, pop_s})
      2'b10: begin
        if (cnt_r == 2'd0) begin
          ent0_s = push_data;
          cnt_s  = 2'd1;
        end else if (cnt_r == 2'd1) begin
          ent1_s = push_data;
          cnt_s  = 2'd2;
        end else begin
          cnt_s = cnt_r;
        end
      end
      2'b01: begin
        ent0_s = ent1_r;
        cnt_s  = cnt_r - 2'd1;
      end
      2'b11: begin
        if (cnt_r == 2'd1) begin
          ent0_s = push_data;
        end else begin
          ent0_s = ent1_r;
          ent1_s = push_data;
        end
      end
      default: begin
        cnt_s = cnt_r;
      end
    endcase
  end

  // Entry, count and valid registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ent0_r <= {W{1'b0}};
      ent1_r <= {W{1'b0}};
      cnt_r  <= 2'd0;
      vld_r  <= 1'b0;
    end else begin
      ent0_r <= ent0_s;
      ent1_r <= ent1_s;
      cnt_r  <= cnt_s;
      vld_r  <= (cnt_s != 2'd0);
    end
  end

endmodule

// File: rtl/axi_rd_slave.sv
// AXI read slave front-end for a 1-cycle-latency word memory. Accepts one AR at a
// time, streams FIXED/INCR bursts from memory and answers other burst types with SLVERR.
module axi_rd_slave
  import axi_pkg::*;
#(
  parameter int DW  = 32,
  parameter int AW  = 32,
  parameter int IDW = 4,
  parameter int MAW = 10
) (
  input  logic           clk_in,
  input  logic           reset,
  input  logic           arvalid,
  output logic           arready,
  input  logic [IDW-1:0] arid,
  input  logic [AW-1:0]  araddr,
  input  logic [7:0]     arlen,
  input  logic [1:0]     arburst,
  output logic           rvalid,
  input  logic           rready,
  output logic [IDW-1:0] rid,
  output logic [DW-1:0]  rdata,
  output logic [1:0]     rresp,
  output logic           rlast,
  output logic           mem_rd_en,
  output logic [MAW-1:0] mem_addr,
  input  logic [DW-1:0]  mem_rdata
);

  localparam int OB = $clog2(DW / 8);
  localparam int BW = IDW + DW + 2 + 1;

  rd_state_e      state_r, state_s;
  logic [IDW-1:0] id_r;
  logic [MAW-1:0] addr_r;
  logic [7:0]     len_r;
  logic           err_r;
  logic           fixed_r;
  logic [8:0]     iss_cnt_r;
  logic           pend_r;
  logic           pend_last_r;

  logic           ar_hs_s;
  logic           issue_s;
  logic           pop_s;
  logic [1:0]     buf_cnt_s;
  logic [2:0]     occ_s;
  logic [BW-1:0]  push_data_s;
  logic [BW-1:0]  out_data_s;
  logic           unused_s;

  assign unused_s = ^araddr;

  assign arready = (state_r == IDLE) & ~reset;
  assign ar_hs_s = arvalid & arready;
  assign pop_s   = rvalid & rready;

  // Beats in flight plus beats that will still sit in the buffer after this cycle's pop.
  // Counting the pop lets a single credit pair sustain one beat per cycle.
  assign occ_s = {2'b00, pend_r} + {1'b0, buf_cnt_s} - {2'b00, pop_s};

  // The read strobe must see this cycle's rready to hit the 2-cycle latency, so it
  // is decoded from registered state rather than registered itself.
  assign mem_rd_en = issue_s & ~err_r;
  assign mem_addr  = addr_r;

  // Next-state and per-cycle issue decision.
  always_comb begin
    state_s = state_r;
    issue_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (ar_hs_s) begin
          state_s = BURST;
        end else begin
          state_s = IDLE;
        end
      end
      BURST: begin
        if (!reset && (iss_cnt_r <= {1'b0, len_r}) && (occ_s < 3'd2)) begin
          issue_s = 1'b1;
        end else begin
          issue_s = 1'b0;
        end
        if (pop_s && rlast) begin
          state_s = IDLE;
        end else begin
          state_s = BURST;
        end
      end
      default: begin
        state_s = IDLE;
        issue_s = 1'b0;
      end
    endcase
  end

  // Burst context capture, address sequencing and in-flight tracking.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_r     <= IDLE;
      id_r        <= {IDW{1'b0}};
      addr_r      <= {MAW{1'b0}};
      len_r       <= 8'd0;
      err_r       <= 1'b0;
      fixed_r     <= 1'b0;
      iss_cnt_r   <= 9'd0;
      pend_r      <= 1'b0;
      pend_last_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      pend_r      <= issue_s;
      pend_last_r <= issue_s & (iss_cnt_r == {1'b0, len_r});
      if (ar_hs_s) begin
        id_r      <= arid;
        addr_r    <= araddr[MAW+OB-1:OB];
        len_r     <= arlen;
        err_r     <= ~burst_supported(arburst);
        fixed_r   <= (arburst == FIXED);
        iss_cnt_r <= 9'd0;
      end else if (issue_s) begin
        iss_cnt_r <= iss_cnt_r + 9'd1;
        if (!fixed_r && !err_r) begin
          addr_r <= addr_r + {{(MAW-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign push_data_s = {id_r,
                        err_r ? {DW{1'b0}} : mem_rdata,
                        err_r ? SLVERR : OKAY,
                        pend_last_r};

  rd_skid_buf #(
    .W(BW)
  ) u_buf (
    .clk       (clk_in),
    .reset     (reset),
    .push      (pend_r),
    .push_data (push_data_s),
    .pop_ready (rready),
    .out_valid (rvalid),
    .out_data  (out_data_s),
    .count     (buf_cnt_s)
  );

  assign {rid, rdata, rresp, rlast} = out_data_s;

endmodule

// File: tb/tb_axi_rd_slave.sv
// Directed plus randomized bench for axi_rd_slave: a transaction-level model predicts
// every R beat and every memory address, a 1-cycle memory answers reads.
module tb_axi_rd_slave;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int IDW = 4;
  localparam int MAW = 10;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
    logic [1:0]     resp;
    logic           last;
  } beat_t;

  logic           clk_in;
  logic           reset;
  logic           arvalid;
  logic           arready;
  logic [IDW-1:0] arid;
  logic [AW-1:0]  araddr;
  logic [7:0]     arlen;
  logic [1:0]     arburst;
  logic           rvalid;
  logic           rready;
  logic [IDW-1:0] rid;
  logic [DW-1:0]  rdata;
  logic [1:0]     rresp;
  logic           rlast;
  logic           mem_rd_en;
  logic [MAW-1:0] mem_addr;
  logic [DW-1:0]  mem_rdata;

  int             errors = 0;
  int             checks = 0;
  int             cyc = 0;
  int             ar_cyc = 0;
  bit             mon_en = 0;
  beat_t          exp_q[$];
  logic [MAW-1:0] addr_q[$];
  int             beat_cycles[$];
  int             rd_cycles[$];

  axi_rd_slave #(
    .DW(DW), .AW(AW), .IDW(IDW), .MAW(MAW)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .arvalid   (arvalid),
    .arready   (arready),
    .arid      (arid),
    .araddr    (araddr),
    .arlen     (arlen),
    .arburst   (arburst),
    .rvalid    (rvalid),
    .rready    (rready),
    .rid       (rid),
    .rdata     (rdata),
    .rresp     (rresp),
    .rlast     (rlast),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial forever begin
    @(posedge clk_in);
    cyc++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [MAW-1:0] a);
    return 32'(a) + 32'h0000_00A0;
  endfunction

  // Memory: data for a read strobed in one cycle is valid throughout the next cycle.
  initial begin
    logic           en;
    logic [MAW-1:0] a;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk_in);
      en = mem_rd_en;
      a  = mem_addr;
      @(posedge clk_in);
      #1;
      mem_rdata = en ? mem_word(a) : $urandom();
    end
  end

  // Monitor: checks memory addresses, R beats against the model and stall stability.
  initial begin
    bit              stall_prev = 0;
    logic [IDW+DW+2:0] prev_pl = '0;
    beat_t           b;
    logic [MAW-1:0]  a;
    forever begin
      @(negedge clk_in);
      if (mon_en) begin
        if (mem_rd_en) begin
          rd_cycles.push_back(cyc);
          chk("rd_expected", addr_q.size() != 0, 1'b1);
          if (addr_q.size() != 0) begin
            a = addr_q.pop_front();
            chk("mem_addr", mem_addr, a);
          end
        end
        if (stall_prev) begin
          chk("stall_rvalid", rvalid, 1'b1);
          chk("stall_payload", {rid, rdata, rresp, rlast}, prev_pl);
        end
        if (rvalid && rready) begin
          beat_cycles.push_back(cyc);
          chk("beat_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            b = exp_q.pop_front();
            chk("rid", rid, b.id);
            chk("rdata", rdata, b.data);
            chk("rresp", rresp, b.resp);
            chk("rlast", rlast, b.last);
          end
        end
        stall_prev = rvalid && !rready;
        prev_pl    = {rid, rdata, rresp, rlast};
      end else begin
        stall_prev = 0;
      end
    end
  end

  // Predict the burst from the AXI rules, then present AR until it is accepted.
  task automatic send_ar(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    logic [MAW-1:0] w;
    logic [MAW-1:0] a;
    beat_t          b;
    bit             ok;
    w = addr[MAW+1:2];
    for (int k = 0; k <= int'(len); k++) begin
      b.id   = id;
      b.last = (k == int'(len));
      if (burst == 2'd0 || burst == 2'd1) begin
        a = (burst == 2'd1) ? w + MAW'(k) : w;
        addr_q.push_back(a);
        b.data = mem_word(a);
        b.resp = 2'd0;
      end else begin
        b.data = 32'h0;
        b.resp = 2'd2;
      end
      exp_q.push_back(b);
    end
    arvalid = 1'b1;
    arid    = id;
    araddr  = addr;
    arlen   = len;
    arburst = burst;
    ok      = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_in);
      if (arready) begin
        ok     = 1;
        ar_cyc = cyc;
        break;
      end
    end
    chk("ar_accept", ok, 1'b1);
    @(posedge clk_in);
    #1;
    arvalid = 1'b0;
  endtask

  // Run R until the model is drained; mode 0: rready=1, 1: 1,0,0 pattern, else random.
  task automatic drain(input int mode, input string tag);
    bit done;
    done = 0;
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && addr_q.size() == 0 && !rvalid) begin
        done = 1;
        break;
      end
      case (mode)
        0:       rready = 1'b1;
        1:       rready = (i % 3 == 0);
        default: rready = ($urandom_range(0, 3) != 0);
      endcase
      @(posedge clk_in);
      #1;
    end
    chk({tag, "_drain"}, done, 1'b1);
    chk({tag, "_idle_arready"}, arready, 1'b1);
    rready = 1'b1;
  endtask

  initial begin
    reset   = 1'b1;
    arvalid = 1'b0;
    arid    = '0;
    araddr  = '0;
    arlen   = 8'd0;
    arburst = 2'd0;
    rready  = 1'b0;

    // Reset values
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_arready", arready, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_payload", {rid, rdata, rresp, rlast}, 64'd0);
    chk("rst_mem_rd_en", mem_rd_en, 1'b0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    @(posedge clk_in);
    #1;
    reset  = 1'b0;
    mon_en = 1;
    @(negedge clk_in);
    chk("post_rst_arready", arready, 1'b1);
    @(posedge clk_in);
    #1;

    // INCR 0x100, arlen=3, full-rate
    rready = 1'b1;
    beat_cycles.delete();
    rd_cycles.delete();
    send_ar(4'd1, 32'h100, 8'd3, 2'd1);
    drain(0, "incr");
    chk("incr_beats", beat_cycles.size(), 4);
    chk("incr_latency", beat_cycles[0] - rd_cycles[0], 2);
    chk("incr_consecutive", beat_cycles[3] - beat_cycles[0], 3);

    // FIXED 0x8, arlen=2
    rd_cycles.delete();
    beat_cycles.delete();
    send_ar(4'd2, 32'h8, 8'd2, 2'd0);
    drain(0, "fixed");
    chk("fixed_reads", rd_cycles.size(), 3);
    chk("fixed_beats", beat_cycles.size(), 3);

    // WRAP, arlen=1: error beats, no memory access
    rd_cycles.delete();
    beat_cycles.delete();
    send_ar(4'd6, 32'h40, 8'd1, 2'd2);
    drain(0, "wrap");
    chk("wrap_reads", rd_cycles.size(), 0);
    chk("wrap_beats", beat_cycles.size(), 2);

    // INCR arlen=7 with rready 1,0,0,...
    beat_cycles.delete();
    send_ar(4'd7, 32'h200, 8'd7, 2'd1);
    drain(1, "toggle");
    chk("toggle_beats", beat_cycles.size(), 8);

    // Back-to-back single-beat bursts
    beat_cycles.delete();
    send_ar(4'd3, 32'h10, 8'd0, 2'd1);
    send_ar(4'd5, 32'h14, 8'd0, 2'd1);
    chk("b2b_ar_gap", ar_cyc - beat_cycles[0], 1);
    drain(0, "b2b");
    chk("b2b_beats", beat_cycles.size(), 2);

    // Reset during beat 2 of an arlen=7 INCR burst
    beat_cycles.delete();
    send_ar(4'd4, 32'h40, 8'd7, 2'd1);
    for (int i = 0; i < 100; i++) begin
      if (beat_cycles.size() >= 2) break;
      @(posedge clk_in);
      #1;
    end
    reset  = 1'b1;
    mon_en = 0;
    @(posedge clk_in);
    #1;
    reset = 1'b0;
    exp_q.delete();
    addr_q.delete();
    mon_en = 1;
    @(negedge clk_in);
    chk("midrst_rvalid", rvalid, 1'b0);
    chk("midrst_arready", arready, 1'b1);
    repeat (10) @(posedge clk_in);
    #1;
    chk("midrst_no_stale", beat_cycles.size(), 2);

    // Recovery burst, then INCR crossing the top of the word space
    send_ar(4'd9, 32'h24, 8'd1, 2'd1);
    drain(0, "recover");
    send_ar(4'd10, 32'hFF8, 8'd3, 2'd1);
    drain(2, "addr_wrap");

    // Randomized bursts including the reserved burst code
    for (int t = 0; t < 10; t++) begin
      send_ar(IDW'($urandom()), $urandom(), 8'($urandom_range(0, 15)),
              2'($urandom_range(0, 3)));
      drain(2, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
